// File: rtl/fp_pkg.sv
// Shared definitions for the signed fixed-point Qm.n datapath (fp_adder, fp_subtractor).
// No logic: default word format plus the representable range of a W-bit signed word.
// The range helpers are constant functions usable in localparam expressions.
package fp_pkg;

    localparam int FP_W_LEN   = 16;
    localparam int FP_W_FRACT = 14;

    // Largest positive value of a w-bit two's-complement word.
    function automatic logic signed [63:0] fp_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value of a w-bit two's-complement word.
    function automatic logic signed [63:0] fp_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fp_range_sat.sv
// Range check of a W_len+1 bit signed value into W_len bits, with wrap or saturation.
// Latency: combinational. Backpressure: none (pure function of d).
// Build option FP_SUB_SATURATE_EN: clamp out-of-range results; otherwise wrap.
module fp_range_sat
    import fp_pkg::*;
#(
    parameter int W_len = FP_W_LEN
) (
    input  logic signed [W_len:0]   d,
    output logic        [W_len-1:0] result,
    output logic                    overflow,
    output logic                    underflow
);

    localparam logic signed [W_len:0] D_MAX = (W_len + 1)'(fp_max(W_len));
    localparam logic signed [W_len:0] D_MIN = (W_len + 1)'(fp_min(W_len));

    // Flags are reported the same way whether or not the result is clamped.
    always_comb begin
        overflow  = (d > D_MAX);
        underflow = (d < D_MIN);
    end

`ifdef FP_SUB_SATURATE_EN
    localparam logic [W_len-1:0] SAT_MAX = W_len'(fp_max(W_len));
    localparam logic [W_len-1:0] SAT_MIN = W_len'(fp_min(W_len));

    // Clamp to the nearest representable value when out of range.
    always_comb begin
        result = d[W_len-1:0];
        if (overflow) begin
            result = SAT_MAX;
        end else if (underflow) begin
            result = SAT_MIN;
        end
    end
`else
    // Two's-complement wrap: keep the low W_len bits.
    always_comb begin
        result = d[W_len-1:0];
    end
`endif

endmodule

// File: rtl/fp_subtractor.sv
// Pipelined signed fixed-point subtractor diff = a - b with range flags and sticky status.
// Latency 2 cycles, 1 result/cycle; in_ready is combinational from out_ready, no bubbles.
// Backpressure: outputs hold while out_ready=0; in_ready drops once both stages are held.
// Build option FP_SUB_SATURATE_EN selects saturation instead of wrap (see fp_range_sat).
module fp_subtractor
    import fp_pkg::*;
#(
    parameter int W_len   = FP_W_LEN,
    parameter int W_fract = FP_W_FRACT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_len-1:0] a,
    input  logic [W_len-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W_len-1:0] diff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             underflow,
    output logic             ovf_sticky,
    output logic             udf_sticky,
    input  logic             flag_clr
);

    // W_fract only documents the binary point; both operands share it so the
    // arithmetic ignores it. Reject formats that cannot exist.
    if ((W_fract < 0) || (W_fract >= W_len)) begin : g_bad_format
        $error("fp_subtractor: W_fract must lie in [0, W_len-1]");
    end

    logic                   s1_valid;
    logic signed [W_len:0]  s1_d;
    logic                   s1_advance;
    logic                   in_xfer;
    logic                   out_xfer;
    logic [W_len-1:0]       rng_result;
    logic                   rng_ovf;
    logic                   rng_udf;

    assign out_xfer   = out_valid && out_ready;
    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign in_xfer    = in_valid && in_ready;

    // Stage 1: full-precision difference, one extra bit so it can never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_d     <= {a[W_len-1], a} - {b[W_len-1], b};
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    fp_range_sat #(
        .W_len (W_len)
    ) u_range (
        .d         (s1_d),
        .result    (rng_result),
        .overflow  (rng_ovf),
        .underflow (rng_udf)
    );

    // Stage 2: registered formatted result; holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            diff      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            diff      <= rng_result;
            overflow  <= rng_ovf;
            underflow <= rng_udf;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky status: set only by flagged transfers; a same-cycle set beats flag_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (ovf_sticky && !flag_clr) || (out_xfer && overflow);
            udf_sticky <= (udf_sticky && !flag_clr) || (out_xfer && underflow);
        end
    end

endmodule

// File: tb/tb_fp_subtractor.sv
// Directed bench for fp_subtractor: vector table plus backpressure, sticky and reset sequences.
// Expected results are hand-computed constants; FP_SUB_SATURATE_EN picks the clamped set.
`timescale 1ns/1ps
module tb_fp_subtractor;

`ifdef FP_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int LIMIT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a_s;
    logic [15:0] b_s;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] diff;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        underflow;
    logic        ovf_sticky;
    logic        udf_sticky;
    logic        flag_clr;

    int n_vec = 0;
    int n_bad = 0;

    fp_subtractor #(.W_len(16), .W_fract(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a_s),
        .b          (b_s),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .diff       (diff),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .underflow  (underflow),
        .ovf_sticky (ovf_sticky),
        .udf_sticky (udf_sticky),
        .flag_clr   (flag_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pick(input logic [15:0] wrapv, input logic [15:0] satv);
        return SAT ? satv : wrapv;
    endfunction

    // Drive one operand pair, then wait (bounded) for out_valid; returns cycles taken.
    task automatic push(input logic [15:0] va, input logic [15:0] vb, output int lat);
        @(negedge clk);
        a_s = va;
        b_s = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    logic [15:0] bp_a[4];
    logic [15:0] bp_b[4];
    logic [15:0] bp_d[4];

    initial begin
        int lat;
        logic exp_ovf_st;
        logic exp_udf_st;
        int sent;
        int recv;
        int first_block;
        int last_xfer;
        int gaps;
        logic rdy;
        logic ov;
        logic orr;
        logic [15:0] dd;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flag_clr = 1'b0;
        a_s = '0;
        b_s = '0;

        tbl[0]  = '{16'h2000, 16'hD000, 16'h5000, 1'b0, 1'b0};
        tbl[1]  = '{16'h5555, 16'h9000, pick(16'hC555, 16'h7FFF), 1'b1, 1'b0};
        tbl[2]  = '{16'h9000, 16'h5555, pick(16'h3AAB, 16'h8000), 1'b0, 1'b1};
        tbl[3]  = '{16'h8000, 16'h0001, pick(16'h7FFF, 16'h8000), 1'b0, 1'b1};
        tbl[4]  = '{16'h0000, 16'h8000, pick(16'h8000, 16'h7FFF), 1'b1, 1'b0};
        tbl[5]  = '{16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0};
        tbl[6]  = '{16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0};
        tbl[7]  = '{16'h0000, 16'h7FFF, 16'h8001, 1'b0, 1'b0};
        tbl[8]  = '{16'hFFFF, 16'h7FFF, 16'h8000, 1'b0, 1'b0};
        tbl[9]  = '{16'h7FFF, 16'hFFFF, pick(16'h8000, 16'h7FFF), 1'b1, 1'b0};
        tbl[10] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};
        tbl[11] = '{16'h4000, 16'hC000, pick(16'h8000, 16'h7FFF), 1'b1, 1'b0};

        bp_a = '{16'h1000, 16'h2000, 16'h3000, 16'h0400};
        bp_b = '{16'h0100, 16'h0200, 16'h0300, 16'h0100};
        bp_d = '{16'h0F00, 16'h1E00, 16'h2D00, 16'h0300};

        // Reset state.
        #12;
        chk("reset_outputs", {26'd0, out_valid, overflow, underflow, ovf_sticky, udf_sticky, (diff != 16'h0)}, 32'd0);
        chk("reset_diff", diff, 32'h0);
        chk("reset_in_ready", in_ready, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Vector table, one transaction at a time, stickies tracked by a small model.
        exp_ovf_st = 1'b0;
        exp_udf_st = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push(tbl[i].a, tbl[i].b, lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd2);
            chk($sformatf("vec%0d_result", i), {14'd0, diff, overflow, underflow},
                {14'd0, tbl[i].d, tbl[i].ovf, tbl[i].udf});
            @(posedge clk);
            #1;
            exp_ovf_st = exp_ovf_st | tbl[i].ovf;
            exp_udf_st = exp_udf_st | tbl[i].udf;
            chk($sformatf("vec%0d_sticky", i), {ovf_sticky, udf_sticky}, {exp_ovf_st, exp_udf_st});
        end

        // Sticky flags: clear, set udf, overflow with clear in the same cycle, then clear alone.
        @(negedge clk);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("sticky_clear_1", {ovf_sticky, udf_sticky}, 32'd0);
        push(16'h9000, 16'h5555, lat);
        @(posedge clk);
        #1;
        chk("sticky_udf_set", {ovf_sticky, udf_sticky}, 32'b01);
        push(16'h5555, 16'h9000, lat);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("sticky_set_wins", ovf_sticky, 32'd1);
        @(negedge clk);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("sticky_clear_2", {ovf_sticky, udf_sticky}, 32'd0);

        // Backpressure: 4 back-to-back inputs, consumer stalled for 3 cycles.
        sent = 0;
        recv = 0;
        first_block = -1;
        last_xfer = -1;
        gaps = 0;
        for (int c = 0; c < 30 && recv < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            in_valid = (sent < 4);
            if (sent < 4) begin
                a_s = bp_a[sent];
                b_s = bp_b[sent];
            end
            #1;
            rdy = in_ready;
            ov = out_valid;
            dd = diff;
            orr = out_ready;
            if (in_valid && !rdy && first_block < 0) first_block = sent;
            if (ov && !orr) chk($sformatf("bp_hold_c%0d", c), dd, bp_d[0]);
            @(posedge clk);
            if (in_valid && rdy) sent++;
            if (ov && orr) begin
                chk($sformatf("bp_out%0d", recv), dd, bp_d[recv]);
                if (last_xfer >= 0 && c != last_xfer + 1) gaps++;
                last_xfer = c;
                recv++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_block_after", first_block, 32'd2);
        chk("bp_count", recv, 32'd4);
        chk("bp_gaps", gaps, 32'd0);

        // Reset with both stages occupied.
        @(negedge clk);
        out_ready = 1'b0;
        a_s = 16'h5555;
        b_s = 16'h9000;
        in_valid = 1'b1;
        @(negedge clk);
        a_s = 16'h2000;
        b_s = 16'hD000;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_full", {out_valid, overflow, in_ready}, 32'b110);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_flags", {out_valid, overflow, underflow, ovf_sticky, udf_sticky}, 32'd0);
        chk("mid_reset_diff", diff, 32'h0);
        chk("mid_reset_in_ready", in_ready, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mid_no_stale%0d", k), out_valid, 32'd0);
        end
        push(16'h2000, 16'hD000, lat);
        chk("mid_after_latency", lat, 32'd2);
        chk("mid_after_result", {diff, overflow, underflow}, {16'h5000, 2'b00});
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_subtractor.md
Name: fp_subtractor

Overview:
- Pipelined signed fixed-point subtractor computing diff = a - b; the inverse-direction companion of fp_adder in the same Qm.n datapath (default Q2.14).
- Valid/ready handshake on input and output, 2 register stages, per-result overflow/underflow flags plus sticky status flags.
- Sits between producers of Q2.14 samples and downstream consumers that may apply backpressure.

Parameters:
- W_len, 16, total word width in bits (signed two's complement).
- W_fract, 14, fractional bits; the value of a word is word / 2^W_fract.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  W_len  minuend, signed Q(W_len-W_fract).W_fract.
- b  input  W_len  subtrahend, same format.
- in_valid  input  1  a/b valid.
- in_ready  output  1  block accepts a/b this cycle.
- diff  output  W_len  result, same format as inputs.
- out_valid  output  1  diff/flags valid.
- out_ready  input  1  consumer accepts diff this cycle.
- overflow  output  1  result for this diff exceeded max positive; qualified by out_valid.
- underflow  output  1  result for this diff was below min negative; qualified by out_valid.
- ovf_sticky  output  1  set by any overflow transfer, held until cleared.
- udf_sticky  output  1  set by any underflow transfer, held until cleared.
- flag_clr  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): both stage valids = 0, out_valid = 0, diff = 0, overflow = 0, underflow = 0, ovf_sticky = 0, udf_sticky = 0. In-flight data is discarded.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Stage 1 (s1): on input transfer, register the full-precision difference sign-extended to W_len+1 bits: a - b.
- Stage 2 (s2/out): range check of the W_len+1 bit difference.
  - overflow = (d > 2^(W_len-1)-1).
  - underflow = (d < -2^(W_len-1)).
  - Both are never set together.
  - diff = formatted result (see Optional Feature).
- Advance rules:
  - s2 loads from s1 when s1 is valid and (s2 is empty or an output transfer occurs).
  - s1 loads when s1 is empty or s1 advances this cycle.
  - in_ready = !s1_valid || s1_advance. This is combinational from out_ready and contains no bubbles.
- Latency: 2 cycles from input transfer to out_valid under no backpressure. Throughput is 1 per cycle.
- Backpressure:
  - While out_ready = 0, diff, overflow and underflow hold stable.
  - A held s2 plus a held s1 gives in_ready = 0. No data is lost or duplicated.
- Sticky flags:
  - Updated only on an output transfer that carries overflow or underflow.
  - When flag_clr and a flagged transfer occur in the same cycle, set wins.
- W_fract is not used by the arithmetic (binary point is aligned for both operands); it documents the format only.

Optional Feature:
- Macro: FP_SUB_SATURATE_EN.
- Defined: on overflow, diff = 2^(W_len-1)-1 (0x7FFF). On underflow, diff = -2^(W_len-1) (0x8000).
- Undefined: diff = low W_len bits of d (two's-complement wrap). Flags are still reported identically.

Decomposition:
- Package fp_pkg:
  - Defaults FP_W_LEN = 16, FP_W_FRACT = 14.
  - Functions/constants for FP_MAX and FP_MIN of a given width.
  - Shared with fp_adder.
- Sub-module fp_range_sat:
  - Combinational; input W_len+1 bit value, outputs W_len result plus overflow/underflow.
  - Contains the FP_SUB_SATURATE_EN selection.
  - Reusable by fp_adder.

Test Plan:
- Normal subtraction: a=0x2000 (0.5), b=0xD000 (-0.75), out_ready=1.
  - 2 cycles later: diff=0x5000 (1.25), overflow=0, underflow=0.
- Overflow: a=0x5555, b=0x9000.
  - With saturation: diff=0x7FFF, overflow=1, ovf_sticky=1.
  - Without saturation: diff=0xC555, overflow=1.
- Underflow: a=0x9000, b=0x5555, then a=0x8000, b=0x0001.
  - With saturation: diff=0x8000, underflow=1 for both.
  - Without saturation: diff=0x3AAB and 0x7FFF respectively.
  - a=0x0000, b=0x8000 → overflow, saturated diff 0x7FFF.
- Backpressure: stream 4 back-to-back inputs with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepted inputs and diff holds.
  - Releasing out_ready delivers all 4 in order with no gaps.
- Sticky flags:
  - flag_clr asserted in the same cycle as an overflow transfer → ovf_sticky stays 1.
  - flag_clr asserted alone next cycle → both sticky flags 0.
- Reset mid-stream: assert reset while s1 and s2 are valid.
  - Outputs go to 0 immediately (asynchronous).
  - After release, the first new input appears after 2 cycles and no stale data emerges.
